// File: rtl/mux_scan_ctrl_pkg.sv
// rtl/mux_scan_ctrl_pkg.sv - shared state encodings and widths for the mux scan sequencer
package mux_scan_ctrl_pkg;

    localparam int SEL_W  = 2;
    localparam int NUM_CH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Dwell counter needs to reach DWELL-1; a DWELL of 1 still gets one bit.
    function automatic int cnt_width(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_dwell_timer.sv
// rtl/mux_scan_ctrl_dwell_timer.sv - per-channel dwell counter, ticks on the last cycle of a dwell
module dwell_timer
    import mux_scan_ctrl_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic En,
    input  logic Clr,
    output logic Tick
);

    localparam int            CW   = cnt_width(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] count;

    // Wraps only through Clr on Tick, never by rolling over.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count <= '0;
        end else if (Clr) begin
            count <= '0;
        end else if (En) begin
            count <= count + CW'(1);
        end
    end

    assign Tick = (count == LAST);

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - steps the Mux4 select through all channels and publishes a 4-bit sample word
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Cont,
    input  logic              Abort,
    input  logic              MuxIn,
    output logic [SEL_W-1:0]  Se1,
    output logic              Busy,
    output logic              Done,
    output logic [NUM_CH-1:0] Result
);

    state_t            state;
    state_t            state_nx;
    logic              tick;
    logic              scanning;
    logic              last_sample;
    logic              cont_q;
    logic [NUM_CH-1:0] shadow;

    assign scanning    = (state == ST_SCAN);
    assign last_sample = scanning && tick && (Se1 == SEL_W'(NUM_CH - 1));

    dwell_timer #(
        .DWELL(DWELL)
    ) u_timer (
        .Clk (Clk),
        .Rst (Rst),
        .En  (scanning),
        .Clr (!scanning || tick || Abort),
        .Tick(tick)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start && !Abort) state_nx = ST_SCAN;
            end
            ST_SCAN: begin
                Busy = 1'b1;
                if (Abort)            state_nx = ST_IDLE;
                else if (last_sample) state_nx = ST_DONE;
            end
            ST_DONE: begin
                Busy = cont_q;
                Done = 1'b1;
                if (Abort)       state_nx = ST_IDLE;
                else if (cont_q) state_nx = ST_SCAN;
                else             state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Select increment wraps 11->00 on the last sample, so DONE hands the next scan a clean select.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Se1    <= '0;
            shadow <= '0;
            Result <= '0;
            cont_q <= 1'b0;
        end else if (Abort && (state != ST_IDLE)) begin
            Se1    <= '0;
            shadow <= '0;
        end else if (scanning && tick) begin
            shadow[Se1] <= MuxIn;
            Se1         <= Se1 + SEL_W'(1);
            if (last_sample) begin
                Result <= {MuxIn, shadow[NUM_CH-2:0]};
                cont_q <= Cont;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - three DWELL variants driven by directed and random stimulus against a timeline model
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start;
    logic [2:0] cont;
    logic [2:0] abort;
    logic [2:0] mux_in;
    logic [2:0] busy;
    logic [2:0] done;
    logic [3:0] in_vec [3];
    logic [1:0] se1    [3];
    logic [3:0] result [3];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    int         m_t    [3];
    bit         m_act  [3];
    bit         m_cont [3];
    logic [3:0] m_samp [3];
    logic [3:0] m_res  [3];
    int         last_done [3];

    always #5 clk = ~clk;

    function automatic int dw(input int g);
        case (g)
            0:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign mux_in[g] = in_vec[g][se1[g]];
        mux_scan_ctrl #(
            .DWELL(dw(g))
        ) u_dut (
            .Clk   (clk),
            .Rst   (rst),
            .Start (start[g]),
            .Cont  (cont[g]),
            .Abort (abort[g]),
            .MuxIn (mux_in[g]),
            .Se1   (se1[g]),
            .Busy  (busy[g]),
            .Done  (done[g]),
            .Result(result[g])
        );
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < 3; g++) begin
            m_t[g]    = 0;
            m_act[g]  = 1'b0;
            m_cont[g] = 1'b0;
            m_samp[g] = 4'h0;
            m_res[g]  = 4'h0;
        end
    endtask

    // m_t counts edges since the edge that accepted Start; m_t == 4*D is the result cycle.
    task automatic model_edge();
        for (int g = 0; g < 3; g++) begin
            int d;
            int c;
            d = dw(g);
            if (!m_act[g]) begin
                if (start[g] && !abort[g]) begin
                    m_act[g] = 1'b1;
                    m_t[g]   = 0;
                end
            end else if (abort[g]) begin
                m_act[g] = 1'b0;
                m_t[g]   = 0;
            end else if (m_t[g] == 4 * d) begin
                if (m_cont[g]) m_t[g] = 0;
                else           m_act[g] = 1'b0;
            end else begin
                m_t[g]++;
                if (m_t[g] % d == 0) begin
                    c = m_t[g] / d - 1;
                    m_samp[g][c] = in_vec[g][c];
                end
                if (m_t[g] == 4 * d) begin
                    m_res[g]  = m_samp[g];
                    m_cont[g] = cont[g];
                end
            end
        end
    endtask

    task automatic compare();
        for (int g = 0; g < 3; g++) begin
            int d;
            bit e_done;
            bit e_busy;
            d      = dw(g);
            e_done = m_act[g] && (m_t[g] == 4 * d);
            e_busy = m_act[g] && ((m_t[g] < 4 * d) || m_cont[g]);
            check($sformatf("g%0d_busy", g), 8'(busy[g]), 8'(e_busy));
            check($sformatf("g%0d_done", g), 8'(done[g]), 8'(e_done));
            check($sformatf("g%0d_result", g), 8'(result[g]), 8'(m_res[g]));
            if (!e_done)
                check($sformatf("g%0d_se1", g), 8'(se1[g]), m_act[g] ? 8'(m_t[g] / d) : 8'h00);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input bit s, input bit c, input bit a);
        start = {3{s}};
        cont  = {3{c}};
        abort = {3{a}};
    endtask

    task automatic rst_pulse();
        #2 rst = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("g%0d_rst_se1", g), 8'(se1[g]), 8'h00);
            check($sformatf("g%0d_rst_busy", g), 8'(busy[g]), 8'h00);
            check($sformatf("g%0d_rst_done", g), 8'(done[g]), 8'h00);
            check($sformatf("g%0d_rst_result", g), 8'(result[g]), 8'h00);
        end
        model_reset();
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0);
        for (int g = 0; g < 3; g++) in_vec[g] = 4'h0;
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        rst = 1'b0;

        // Single scan; Start re-asserted mid-scan must be ignored.
        in_vec[0] = 4'b1101;
        in_vec[1] = 4'($urandom);
        in_vec[2] = 4'b0110;
        drive(1, 0, 0);
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (k == 4) begin
                check("d1_done", 8'(done[2]), 8'h01);
                check("d1_result", 8'(result[2]), 8'h06);
            end
            if (k == 16) begin
                check("d4_done", 8'(done[0]), 8'h01);
                check("d4_result", 8'(result[0]), 8'h0d);
                check("d4_busy", 8'(busy[0]), 8'h00);
            end
            if (k == 17) check("d4_done_clr", 8'(done[0]), 8'h00);
            drive((k == 4) || (k == 5), 0, 0);
        end
        drive(0, 0, 0);
        repeat (10) cycle();

        // Abort at edge 10 of a DWELL=4 scan keeps the previous result.
        in_vec[0] = 4'b0010;
        drive(1, 0, 0);
        for (int k = 0; k < 16; k++) begin
            cycle();
            if (k == 10) begin
                check("abort_busy", 8'(busy[0]), 8'h00);
                check("abort_se1", 8'(se1[0]), 8'h00);
                check("abort_result", 8'(result[0]), 8'h0d);
            end
            drive(0, 0, k == 9);
        end

        // Continuous scanning with inputs changing between and during scans.
        for (int g = 0; g < 3; g++) last_done[g] = -1;
        drive(1, 1, 0);
        for (int k = 0; k < 60; k++) begin
            cycle();
            for (int g = 0; g < 3; g++) begin
                if (done[g]) begin
                    if (last_done[g] >= 0)
                        check($sformatf("g%0d_period", g), 8'(cyc - last_done[g]), 8'(4 * dw(g) + 1));
                    last_done[g] = cyc;
                end
                if ($urandom_range(2) == 0) in_vec[g] = 4'($urandom);
            end
            drive(0, 1, 0);
        end
        drive(0, 0, 0);
        repeat (20) cycle();

        // Async reset in the middle of a scan, then a clean restart.
        drive(1, 0, 0);
        cycle();
        drive(0, 0, 0);
        repeat (4) cycle();
        rst_pulse();
        cycle();
        drive(1, 0, 0);
        cycle();
        drive(0, 0, 0);
        repeat (24) cycle();

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            for (int g = 0; g < 3; g++) begin
                start[g] = ($urandom_range(3) == 0);
                cont[g]  = $urandom_range(1) == 1;
                abort[g] = ($urandom_range(15) == 0);
                if ($urandom_range(3) == 0) in_vec[g] = 4'($urandom);
            end
            if ($urandom_range(149) == 0) rst_pulse();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
